// File: rtl/preempt_timer_ctrl.sv
// Preemption quantum timer with interrupt request, PC capture and read-to-clear cause register.
// Optional external Button interrupt is compiled in when EXT_IRQ_EN is defined.
module preempt_timer_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        setClock,
  input  logic [15:0] quantum_in,
  input  logic        getInterruption,
  input  logic        EnableClock,
  input  logic        Halt,
  input  logic [31:0] pc_in,
  input  logic        irq_ack,
  input  logic        Button,
  output logic        irq,
  output logic [31:0] pc_buffer,
  output logic [31:0] int_cause,
  output logic [15:0] timer_value
);

  typedef enum logic [1:0] {IDLE, RUN, PEND, SERV} state_t;

  state_t      state_q;
  logic [15:0] count_q;
  logic        irq_q;
  logic [31:0] pcBuffer_q;
  logic [1:0]  cause_q;
  logic [1:0]  cause_d;
  logic        extEdge;
  logic        decEn;
  logic        timerFire;

`ifdef EXT_IRQ_EN
  // Two synchroniser stages followed by one history stage for rising-edge detection.
  logic [2:0] btnSync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btnSync_q <= 3'b000;
    end else begin
      btnSync_q <= {btnSync_q[1:0], Button};
    end
  end

  assign extEdge = btnSync_q[1] & ~btnSync_q[2];
`else
  logic unusedButton;
  assign unusedButton = Button;
  assign extEdge      = 1'b0;
`endif

  assign decEn     = EnableClock & ~Halt;
  assign timerFire = (state_q == RUN) && !setClock && !extEdge && decEn && (count_q <= 16'd1);

  // A newly raised cause survives a simultaneous read-to-clear.
  assign cause_d = (getInterruption ? 2'b00 : cause_q) | {extEdge, timerFire};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= 16'd0;
      irq_q      <= 1'b0;
      pcBuffer_q <= 32'd0;
      cause_q    <= 2'b00;
    end else begin
      cause_q <= cause_d;
      if (state_q == PEND && irq_ack) begin
        pcBuffer_q <= pc_in;
      end
      if (setClock) begin
        count_q <= quantum_in;
        state_q <= (quantum_in != 16'd0) ? RUN : IDLE;
        irq_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (extEdge) begin
              state_q <= PEND;
              irq_q   <= 1'b1;
            end
          end
          RUN: begin
            if (extEdge) begin
              state_q <= PEND;
              irq_q   <= 1'b1;
            end else if (timerFire) begin
              count_q <= 16'd0;
              state_q <= PEND;
              irq_q   <= 1'b1;
            end else if (decEn) begin
              count_q <= count_q - 16'd1;
            end
          end
          PEND: begin
            if (irq_ack) begin
              state_q <= SERV;
              irq_q   <= 1'b0;
            end
          end
          SERV: begin
            irq_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign irq         = irq_q;
  assign pc_buffer   = pcBuffer_q;
  assign int_cause   = {30'd0, cause_q};
  assign timer_value = count_q;

endmodule

// File: tb/tb_preempt_timer_ctrl.sv
// Directed self-checking bench for preempt_timer_ctrl; define EXT_IRQ_EN to exercise the Button path.
module tb_preempt_timer_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        setClock;
  logic [15:0] quantum_in;
  logic        getInterruption;
  logic        EnableClock;
  logic        Halt;
  logic [31:0] pc_in;
  logic        irq_ack;
  logic        Button;
  logic        irq;
  logic [31:0] pc_buffer;
  logic [31:0] int_cause;
  logic [15:0] timer_value;

  int checkCount = 0;
  int passCount  = 0;

  preempt_timer_ctrl dut (
    .clock(clock), .reset(reset), .setClock(setClock), .quantum_in(quantum_in),
    .getInterruption(getInterruption), .EnableClock(EnableClock), .Halt(Halt),
    .pc_in(pc_in), .irq_ack(irq_ack), .Button(Button), .irq(irq),
    .pc_buffer(pc_buffer), .int_cause(int_cause), .timer_value(timer_value)
  );

  always #5 clock = ~clock;

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; setClock = 1'b0; quantum_in = 16'd0; getInterruption = 1'b0;
    EnableClock = 1'b1; Halt = 1'b0; pc_in = 32'd0; irq_ack = 1'b0; Button = 1'b0;
    #3;
    checkCount++; if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b want 0", irq); else passCount++;
    checkCount++; if (pc_buffer !== 32'd0) $display("[TB] FAIL reset_pc: got %h want 0", pc_buffer); else passCount++;
    checkCount++; if (int_cause !== 32'd0) $display("[TB] FAIL reset_cause: got %h want 0", int_cause); else passCount++;
    checkCount++; if (timer_value !== 16'd0) $display("[TB] FAIL reset_timer: got %0d want 0", timer_value); else passCount++;
    #4 reset = 1'b1;
    tick();
  endtask

  task automatic test_countdown();
    setClock = 1'b1; quantum_in = 16'd5;
    tick();
    setClock = 1'b0;
    checkCount++; if (timer_value !== 16'd5) $display("[TB] FAIL load5: got %0d want 5", timer_value); else passCount++;
    for (int v = 4; v >= 1; v--) begin
      tick();
      checkCount++;
      if (timer_value !== 16'(v) || irq !== 1'b0)
        $display("[TB] FAIL count_%0d: timer %0d irq %b want %0d irq 0", v, timer_value, irq, v);
      else passCount++;
    end
    tick();
    checkCount++; if (timer_value !== 16'd0) $display("[TB] FAIL expire_timer: got %0d want 0", timer_value); else passCount++;
    checkCount++; if (irq !== 1'b1) $display("[TB] FAIL expire_irq: got %b want 1", irq); else passCount++;
    checkCount++; if (int_cause !== 32'h1) $display("[TB] FAIL expire_cause: got %h want 1", int_cause); else passCount++;
    pc_in = 32'h0000_0040; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkCount++; if (pc_buffer !== 32'h40) $display("[TB] FAIL ack_pc: got %h want 40", pc_buffer); else passCount++;
    checkCount++; if (irq !== 1'b0) $display("[TB] FAIL ack_irq: got %b want 0", irq); else passCount++;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkCount++;
      if (timer_value !== 16'd0 || irq !== 1'b0)
        $display("[TB] FAIL serv_hold_%0d: timer %0d irq %b want 0 irq 0", i, timer_value, irq);
      else passCount++;
    end
  endtask

  task automatic test_read_clear();
    getInterruption = 1'b1;
    #1;
    checkCount++; if (int_cause !== 32'h1) $display("[TB] FAIL read_cycle: got %h want 1", int_cause); else passCount++;
    tick();
    getInterruption = 1'b0;
    checkCount++; if (int_cause !== 32'h0) $display("[TB] FAIL read_clear: got %h want 0", int_cause); else passCount++;
  endtask

  task automatic test_stall();
    int edges;
    edges = 0;
    setClock = 1'b1; quantum_in = 16'd5; EnableClock = 1'b1;
    tick(); edges++;
    setClock = 1'b0;
    tick(); edges++;
    tick(); edges++;
    EnableClock = 1'b0;
    repeat (3) begin tick(); edges++; end
    checkCount++; if (timer_value !== 16'd3) $display("[TB] FAIL stall_hold: got %0d want 3", timer_value); else passCount++;
    EnableClock = 1'b1;
    while (irq !== 1'b1 && edges < 20) begin tick(); edges++; end
    checkCount++; if (edges !== 9) $display("[TB] FAIL stall_latency: got %0d edges want 9", edges); else passCount++;
    pc_in = 32'h0000_0080; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_ack_with_reload();
    setClock = 1'b1; quantum_in = 16'd1;
    tick();
    setClock = 1'b0;
    tick();
    checkCount++; if (irq !== 1'b1) $display("[TB] FAIL q1_irq: got %b want 1", irq); else passCount++;
    irq_ack = 1'b1; setClock = 1'b1; quantum_in = 16'd8; pc_in = 32'h0000_1234;
    tick();
    irq_ack = 1'b0; setClock = 1'b0;
    checkCount++; if (pc_buffer !== 32'h1234) $display("[TB] FAIL reload_pc: got %h want 1234", pc_buffer); else passCount++;
    checkCount++; if (timer_value !== 16'd8) $display("[TB] FAIL reload_timer: got %0d want 8", timer_value); else passCount++;
    checkCount++; if (irq !== 1'b0) $display("[TB] FAIL reload_irq: got %b want 0", irq); else passCount++;
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    checkCount++; if (timer_value !== 16'd8) $display("[TB] FAIL halt_hold: got %0d want 8", timer_value); else passCount++;
    tick();
    checkCount++; if (timer_value !== 16'd7) $display("[TB] FAIL run_after_reload: got %0d want 7", timer_value); else passCount++;
    irq_ack = 1'b1; pc_in = 32'h0000_5555;
    tick();
    irq_ack = 1'b0;
    checkCount++; if (pc_buffer !== 32'h1234) $display("[TB] FAIL ack_outside_pend: got %h want 1234", pc_buffer); else passCount++;
  endtask

  task automatic test_cancel();
    getInterruption = 1'b1;
    tick();
    getInterruption = 1'b0;
    setClock = 1'b1; quantum_in = 16'd1;
    tick();
    setClock = 1'b0;
    tick();
    setClock = 1'b1; quantum_in = 16'd0; pc_in = 32'h0000_DEAD;
    tick();
    setClock = 1'b0;
    checkCount++; if (irq !== 1'b0) $display("[TB] FAIL cancel_irq: got %b want 0", irq); else passCount++;
    checkCount++; if (pc_buffer !== 32'h1234) $display("[TB] FAIL cancel_pc: got %h want 1234", pc_buffer); else passCount++;
    checkCount++; if (int_cause !== 32'h1) $display("[TB] FAIL cancel_cause: got %h want 1", int_cause); else passCount++;
    tick();
    checkCount++;
    if (irq !== 1'b0 || timer_value !== 16'd0)
      $display("[TB] FAIL cancel_idle: irq %b timer %0d want irq 0 timer 0", irq, timer_value);
    else passCount++;
  endtask

  task automatic test_set_and_read();
    setClock = 1'b1; quantum_in = 16'd1;
    tick();
    setClock = 1'b0; getInterruption = 1'b1;
    tick();
    getInterruption = 1'b0;
    checkCount++; if (int_cause !== 32'h1) $display("[TB] FAIL set_wins_clear: got %h want 1", int_cause); else passCount++;
  endtask

  task automatic test_reset_in_pend();
    checkCount++; if (irq !== 1'b1) $display("[TB] FAIL pre_reset_irq: got %b want 1", irq); else passCount++;
    #2 reset = 1'b0;
    #1;
    checkCount++;
    if (irq !== 1'b0 || pc_buffer !== 32'd0 || int_cause !== 32'd0 || timer_value !== 16'd0)
      $display("[TB] FAIL async_reset: irq %b pc %h cause %h timer %0d want all 0", irq, pc_buffer, int_cause, timer_value);
    else passCount++;
    #3 reset = 1'b1;
    tick();
    checkCount++; if (irq !== 1'b0) $display("[TB] FAIL post_reset_idle: got %b want 0", irq); else passCount++;
    setClock = 1'b1; quantum_in = 16'd3;
    tick();
    setClock = 1'b0;
    checkCount++; if (timer_value !== 16'd3) $display("[TB] FAIL post_reset_load: got %0d want 3", timer_value); else passCount++;
  endtask

  task automatic test_button();
    setClock = 1'b1; quantum_in = 16'd22;
    tick();
    setClock = 1'b0;
    tick();
    tick();
    checkCount++; if (timer_value !== 16'd20) $display("[TB] FAIL btn_setup: got %0d want 20", timer_value); else passCount++;
    Button = 1'b1;
    tick();
    Button = 1'b0;
`ifdef EXT_IRQ_EN
    begin
      int waitCycles;
      waitCycles = 0;
      while (irq !== 1'b1 && waitCycles < 3) begin tick(); waitCycles++; end
      checkCount++; if (irq !== 1'b1) $display("[TB] FAIL ext_irq: got %b want 1 within 3 cycles", irq); else passCount++;
      checkCount++; if (int_cause !== 32'h2) $display("[TB] FAIL ext_cause: got %h want 2", int_cause); else passCount++;
      checkCount++; if (timer_value !== 16'd18) $display("[TB] FAIL ext_timer: got %0d want 18", timer_value); else passCount++;
      tick();
      checkCount++; if (timer_value !== 16'd18) $display("[TB] FAIL ext_hold: got %0d want 18", timer_value); else passCount++;
    end
`else
    repeat (4) tick();
    checkCount++; if (irq !== 1'b0) $display("[TB] FAIL btn_ignored_irq: got %b want 0", irq); else passCount++;
    checkCount++; if (int_cause !== 32'h0) $display("[TB] FAIL btn_ignored_cause: got %h want 0", int_cause); else passCount++;
    checkCount++; if (timer_value !== 16'd15) $display("[TB] FAIL btn_ignored_timer: got %0d want 15", timer_value); else passCount++;
`endif
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_read_clear();
    test_stall();
    test_ack_with_reload();
    test_cancel();
    test_set_and_read();
    test_reset_in_pend();
    test_button();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
